// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result/flags and an iterative signed multiplier.
// Optional build macro SEQ_ALU_SAT_EN makes ADD/SUB saturate on signed overflow.
`timescale 1ns/1ps
module seq_alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [2:0]            flags
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [W:0]      hi, mc;
  logic [W-1:0]    lo;
  logic            qm1;
  logic            mulh;
  logic [CW-1:0]   cnt;

  logic            out_free, accept, is_mul, fin;
  logic [W-1:0]    sum, dif, alu_r, prod;
  logic            ov_add, ov_sub, alu_v;
  logic [W:0]      s_hi, s_mc, bsum, n_hi;
  logic [W-1:0]    s_lo, n_lo;
  logic            s_q, n_q;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ctrl[2:1] == 2'b10);
  assign fin      = (state == BUSY) && (cnt == '0) && out_free;
  assign prod     = mulh ? hi[W-1:0] : lo;

  assign sum    = A + B;
  assign dif    = A - B;
  assign ov_add = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
  assign ov_sub = (A[W-1] != B[W-1]) && (dif[W-1] != A[W-1]);

  always_comb begin
    alu_r = B;
    alu_v = 1'b0;
    unique case (1'b1)
      (ctrl == 3'b000): begin
        alu_r = sum;
        alu_v = ov_add;
      end
      (ctrl == 3'b001): begin
        alu_r = dif;
        alu_v = ov_sub;
      end
      (ctrl == 3'b010): alu_r = A & B;
      (ctrl == 3'b011): alu_r = A | B;
      default:          alu_r = B;
    endcase
`ifdef SEQ_ALU_SAT_EN
    // overflow always pushes toward the sign of A
    if (alu_v)
      alu_r = A[W-1] ? {1'b1, {(W-1){1'b0}}}
                     : {1'b0, {(W-1){1'b1}}};
`endif
  end

  // first Booth step runs on the accept edge straight from the operands
  always_comb begin
    if (state == IDLE) begin
      s_hi = '0;
      s_lo = B;
      s_q  = 1'b0;
      s_mc = {A[W-1], A};
    end else begin
      s_hi = hi;
      s_lo = lo;
      s_q  = qm1;
      s_mc = mc;
    end
    unique case ({s_lo[0], s_q})
      2'b01:   bsum = s_hi + s_mc;
      2'b10:   bsum = s_hi - s_mc;
      default: bsum = s_hi;
    endcase
    n_hi = {bsum[W], bsum[W:1]};
    n_lo = {bsum[0], s_lo[W-1:1]};
    n_q  = s_lo[0];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_n = BUSY;
      BUSY: if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      qm1       <= 1'b0;
      mc        <= '0;
      mulh      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 3'b000;
    end else begin
      state <= state_n;
      if (accept && is_mul) begin
        hi   <= n_hi;
        lo   <= n_lo;
        qm1  <= n_q;
        mc   <= s_mc;
        mulh <= ctrl[0];
        cnt  <= CW'(W - 1);
      end else if (state == BUSY && cnt != '0) begin
        hi  <= n_hi;
        lo  <= n_lo;
        qm1 <= n_q;
        cnt <= cnt - CW'(1);
      end
      if (accept && !is_mul) begin
        result    <= alu_r;
        flags     <= {alu_v, alu_r[W-1], alu_r == '0};
        out_valid <= 1'b1;
      end else if (fin) begin
        result    <= prod;
        flags     <= {1'b0, prod[W-1], prod == '0};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
